// File: rtl/vote_session_ctrl.sv
// Sessioned three-voter ballot controller (A holds veto): collects one vote per voter, then registers and holds the decision.
// Optional build macro VOTE_TIMEOUT_EN closes a COLLECT session after TIMEOUT cycles, counting missing ballots as 0.
module vote_session_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [2:0] vote_valid,
    input  logic [2:0] vote_val,
    output logic       busy,
    output logic [2:0] voted,
    output logic       done,
    output logic       pass,
    output logic       none,
    output logic       timed_out,
    output logic [7:0] round_cnt
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (HOLD_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("vote_session_ctrl: HOLD_CYCLES and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t          state, state_n;
    logic [2:0]      ballot, ballot_n, voted_n, acc, eff;
    logic [HW-1:0]   hcnt, hcnt_n;
    logic            busy_n, done_n, pass_n, none_n, to_n;
    logic [7:0]      round_n;
    logic            complete, expire;

`ifdef VOTE_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tcnt;

    // Counter is held at zero outside COLLECT, so it is already clear on entry.
    always_ff @(posedge clk) begin
        if (rst || state != COLLECT) tcnt <= '0;
        else                         tcnt <= tcnt + TW'(1);
    end

    assign expire = (state == COLLECT) && (tcnt == TW'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        voted_n  = voted;
        ballot_n = ballot;
        hcnt_n   = hcnt;
        done_n   = 1'b0;
        pass_n   = pass;
        none_n   = none;
        to_n     = timed_out;
        round_n  = round_cnt;
        acc      = 3'b000;
        if (state == COLLECT) acc = vote_valid & ~voted;
        eff      = voted | acc;
        complete = (eff == 3'b111);

        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = COLLECT;
                    voted_n  = 3'b000;
                    ballot_n = 3'b000;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    voted_n  = eff;
                    ballot_n = ballot | (acc & vote_val);
                    // Same-edge strobes are folded into the decision; completion beats timeout.
                    if (complete || expire) begin
                        state_n = HOLD;
                        hcnt_n  = '0;
                        done_n  = 1'b1;
                        pass_n  = ballot_n[2] & (ballot_n[1] | ballot_n[0]);
                        none_n  = ~|ballot_n;
                        to_n    = ~complete;
                        round_n = round_cnt + 8'd1;
                    end
                end
            end
            HOLD: begin
                if (hcnt == HW'(HOLD_CYCLES - 1)) state_n = IDLE;
                else                              hcnt_n  = hcnt + HW'(1);
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            voted     <= 3'b000;
            ballot    <= 3'b000;
            hcnt      <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            none      <= 1'b0;
            timed_out <= 1'b0;
            round_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            busy      <= busy_n;
            voted     <= voted_n;
            ballot    <= ballot_n;
            hcnt      <= hcnt_n;
            done      <= done_n;
            pass      <= pass_n;
            none      <= none_n;
            timed_out <= to_n;
            round_cnt <= round_n;
        end
    end
endmodule

// File: doc/vote_session_ctrl.md
# vote_session_ctrl

Sequential controller for the three-voter ballot (voter A holds veto, voters B and C are ordinary). It opens a voting session on request and collects one vote per voter through per-voter valid strobes. It closes the session when all three have voted (or, optionally, on timeout), then registers the decision and holds it for display. It sits between the voter push-buttons/debouncers and the result LEDs, replacing the free-running combinational evaluation with a sessioned, one-vote-per-voter scheme.

## Interface
- HOLD_CYCLES, default 4: cycles the block stays in HOLD after a decision (≥1).
- TIMEOUT, default 16: COLLECT-state cycle limit; used only with VOTE_TIMEOUT_EN (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  open a session; honoured only in IDLE.
- abort  in  1  cancel the current session; honoured only in COLLECT.
- vote_valid  in  3  per-voter strobe, bit2=A, bit1=B, bit0=C.
- vote_val  in  3  per-voter ballot (1=yes), sampled with the matching vote_valid bit.
- busy  out  1  high in COLLECT and HOLD.
- voted  out  3  voters whose ballot has been accepted in the current session.
- done  out  1  one-cycle pulse, the first cycle of HOLD.
- pass  out  1  registered decision: A=1 and (B=1 or C=1).
- none  out  1  registered flag: no yes votes among the counted ballots.
- timed_out  out  1  the last decision closed on timeout.
- round_cnt  out  8  number of completed decisions, modulo 256.

## Operation
- States: IDLE, COLLECT, HOLD. All outputs are registered.
- Reset (any state, any cycle): state to IDLE. busy, voted, done, pass, none, timed_out and round_cnt all go to 0. Ballot registers go to 0.
- IDLE: start=1 moves to COLLECT. On that edge, voted and the ballot registers clear. pass, none and timed_out keep the previous result until the next decision.
- COLLECT, per voter i: vote_valid[i]=1 with voted[i]=0 sets voted[i] and stores vote_val[i].
  - Repeat strobes from a voter that has already voted are ignored; the first ballot stands.
  - Strobes outside COLLECT are ignored.
- Completion: the session completes when the effective voted vector is 3'b111. The effective vector is the registered voted ORed with this cycle's accepted strobes, so the last vote and completion can fall on the same edge.
  - On the completion edge, state goes to HOLD and pass/none are computed from the ballots including same-cycle ones.
  - On the same edge, done is set, round_cnt increments (255 wraps to 0), and timed_out is set to 0.
- abort in COLLECT: state goes to IDLE. No decision, no done, and round_cnt is unchanged. voted holds until the next start.
- abort and completion in the same cycle: abort wins.
- HOLD: done is high only in its first cycle. After HOLD_CYCLES cycles the block returns to IDLE. start and abort are ignored in HOLD.
- Decision width rules: pass = a & (b | c). none = ~(a | b | c). Missing ballots count as 0.

## Timing
- start sampled at edge N: busy=1 and state=COLLECT from N.
- Last vote accepted at edge M: done=1, busy=1 and pass/none valid from M, for the cycle M..M+1.
- HOLD lasts edges M..M+HOLD_CYCLES. busy=0 and state=IDLE after edge M+HOLD_CYCLES.
- Fastest session: start at N, all three strobes at N+1, done after N+1. That is 2 cycles from start to done.
- A start asserted in the IDLE cycle right after HOLD is accepted. No dead cycle.

## Configuration
- VOTE_TIMEOUT_EN defined:
  - A counter clears on entry to COLLECT and increments each COLLECT cycle.
  - When it reaches TIMEOUT-1 without completion, the session closes on that edge: missing voters count as 0, timed_out=1, and done/round_cnt behave as a normal decision.
  - Votes accepted on the timeout edge are counted.
  - Completion on the same edge takes precedence, with timed_out=0. abort takes precedence over both.
- VOTE_TIMEOUT_EN undefined: COLLECT waits indefinitely. There is no counter, timed_out is tied to 0, and TIMEOUT is unused.

## Test plan
- Reset then idle for 5 cycles -> all outputs 0, busy=0.
- start; strobes A=1, then B=0, then C=1 on separate cycles -> done pulse one cycle after C's edge, pass=1, none=0, round_cnt=1. busy drops after 4 HOLD cycles.
- start; all strobes in one cycle with vote_val=3'b000 -> pass=0, none=1, done one cycle later. Also covers the reference truth table: sweep all 8 vote_val patterns, pass=1 only for 101/110/111, none=1 only for 000.
- start; A strobes yes, then A strobes no, then B=1, C=0 -> second A strobe ignored, pass=1.
- start; A=1, then abort -> IDLE, no done, round_cnt unchanged. abort asserted together with the completing strobe -> no decision.
- With VOTE_TIMEOUT_EN and TIMEOUT=16: start, only A=1 and B=1 vote -> close after 16 COLLECT cycles, pass=1, timed_out=1. Run 256 sessions -> round_cnt wraps to 0. Assert rst mid-COLLECT -> all outputs 0 next cycle.
